bintobcd_seq: RTL

BINTOBCD_SEQ -- requirements
Module: bintobcd_seq

---
 rtl/bintobcd_seq_if.sv | 31 +++
 rtl/bintobcd_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bintobcd_seq_if.sv
// rtl/bintobcd_seq_if.sv - request/result bundle for the sequential binary-to-BCD converter
//
// Signals:
//   start - conversion request (master -> slave)
//   binin - 11-bit signed two's-complement value (master -> slave)
//   BCD   - eight display nibbles, nibble0 = BCD[3:0] (slave -> master)
//   busy  - conversion in progress (slave -> master)
//   done  - one-cycle pulse when BCD is updated (slave -> master)
interface bintobcd_seq_if;
    logic        start;
    logic [10:0] binin;
    logic [31:0] BCD;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output binin,
        input  BCD,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  binin,
        output BCD,
        output busy,
        output done
    );
endinterface

// File: rtl/bintobcd_seq.sv
// rtl/bintobcd_seq.sv - sequential signed binary to display-BCD converter (double-dabble)
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high
//   bus   - bintobcd_seq_if slave: start, binin in; BCD, busy, done out
// Parameter:
//   LEADING_BLANK - 1: leading zero digits shown as 4'hF, 0: shown as 4'h0
// Nibble codes: 4'h0-4'h9 digit, 4'hE minus sign, 4'hF blank.
module bintobcd_seq #(
    parameter bit LEADING_BLANK = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    bintobcd_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_sign;
    logic [10:0] r_mag;
    logic [15:0] r_scratch;
    logic [31:0] r_bcd;
    logic        r_done;

    logic [10:0] w_mag_in;
    logic [15:0] w_adj;
    logic [1:0]  w_msd;
    logic [2:0]  w_sign_pos;
    logic [31:0] w_fmt;

    // -1024 negates to 11'b100_0000_0000, which read unsigned is 1024.
    assign w_mag_in = bus.binin[10] ? (~bus.binin + 11'd1) : bus.binin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = SHIFT;
            SHIFT:   if (r_cnt == 4'd10) w_next = FORMAT;
            FORMAT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction applied before each shift so the doubled nibble stays decimal.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 4; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display formatting: locate the highest non-zero digit (nibble0 if all
    // zero), blank everything above it, and place the sign just above it.
    always_comb begin
        w_msd = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (r_scratch[4*i +: 4] != 4'h0) begin
                w_msd = i[1:0];
            end
        end

        w_fmt = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            if (!LEADING_BLANK || (i[1:0] <= w_msd)) begin
                w_fmt[4*i +: 4] = r_scratch[4*i +: 4];
            end
        end

        w_sign_pos = LEADING_BLANK ? ({1'b0, w_msd} + 3'd1) : 3'd4;
        if (r_sign) begin
            w_fmt[{w_sign_pos, 2'b00} +: 4] = 4'hE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_sign    <= 1'b0;
            r_mag     <= 11'd0;
            r_scratch <= 16'd0;
            r_bcd     <= 32'hFFFF_FFF0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sign    <= bus.binin[10];
                        r_mag     <= w_mag_in;
                        r_scratch <= 16'd0;
                        r_cnt     <= 4'd0;
                    end
                end
                SHIFT: begin
                    r_scratch <= {w_adj[14:0], r_mag[10]};
                    r_mag     <= {r_mag[9:0], 1'b0};
                    r_cnt     <= r_cnt + 4'd1;
                end
                FORMAT: begin
                    r_bcd  <= w_fmt;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.BCD  = r_bcd;
    assign bus.done = r_done;

endmodule
